// File: rtl/note_judge.sv
// Note highway and hit judge: per-lane note shift register, per-player
// press-edge judging against a window around the target row, and
// saturating score/combo with a combo-driven multiplier.
module note_judge #(
   parameter int LANES      = 4,
   parameter int PLAYERS    = 2,
   parameter int DEPTH      = 360,
   parameter int HIT_ROW    = 340,
   parameter int WINDOW     = 8,
   parameter int SCORE_W    = 10,
   parameter int COMBO_W    = 8,
   parameter int COMBO_STEP = 10,
   parameter int MULT_MAX   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       run,
   input  logic                       frame_tick,
   input  logic                       clear,
   input  logic                       score_clr,
   input  logic [LANES-1:0]           notes_in,
   input  logic [PLAYERS*LANES-1:0]   keys,
   output logic [LANES*DEPTH-1:0]     n_reg,
   output logic [PLAYERS*SCORE_W-1:0] score,
   output logic [PLAYERS*COMBO_W-1:0] combo,
   output logic [PLAYERS*LANES-1:0]   hit_pulse,
   output logic [PLAYERS-1:0]         miss_pulse
);

   localparam int WLEN      = 2 * WINDOW + 1;
   localparam int LO        = HIT_ROW - WINDOW;
   localparam int HI        = HIT_ROW + WINDOW;
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;
   localparam int COMBO_MAX = (1 << COMBO_W) - 1;

   // Consumed flags: bit (p*LANES+l)*WLEN+i covers window row LO+i.
   logic [LANES*DEPTH-1:0]        n_q, n_d;
   logic [PLAYERS*LANES*WLEN-1:0] cons_q, cons_d;
   logic [PLAYERS*SCORE_W-1:0]    score_q, score_d;
   logic [PLAYERS*COMBO_W-1:0]    combo_q, combo_d;
   logic [PLAYERS*LANES-1:0]      hit_q, hit_d;
   logic [PLAYERS-1:0]            miss_q, miss_d;
   logic [PLAYERS*LANES-1:0]      keys_prev_q;
   logic [PLAYERS*LANES-1:0]      press;
   logic                          found;
   logic                          bad;
   int                            hits;
   int                            mult;

   function automatic int mult_of(input logic [COMBO_W-1:0] c);
      int m;
      m = 1 + int'(c) / COMBO_STEP;
      if (m > MULT_MAX) m = MULT_MAX;
      return m;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s, input int add);
      int sum;
      sum = int'(s) + add;
      if (sum > SCORE_MAX) return '1;
      return sum[SCORE_W-1:0];
   endfunction

   function automatic logic [COMBO_W-1:0] sat_combo(input logic [COMBO_W-1:0] c, input int add);
      int sum;
      sum = int'(c) + add;
      if (sum > COMBO_MAX) return '1;
      return sum[COMBO_W-1:0];
   endfunction

   // Judge presses on pre-shift rows, consume, account score/combo, then shift on tick.
   always_comb begin
      n_d     = n_q;
      cons_d  = cons_q;
      score_d = score_q;
      combo_d = combo_q;
      hit_d   = '0;
      miss_d  = '0;
      found   = 1'b0;
      bad     = 1'b0;
      hits    = 0;
      mult    = 1;
      press   = keys & ~keys_prev_q;
      if (clear) begin
         n_d    = '0;
         cons_d = '0;
      end else if (run) begin
         for (int p = 0; p < PLAYERS; p++) begin
            hits = 0;
            bad  = 1'b0;
            mult = mult_of(combo_q[p*COMBO_W +: COMBO_W]);
            for (int l = 0; l < LANES; l++) begin
               if (press[p*LANES+l]) begin
                  found = 1'b0;
                  // Highest row first: the note closest to leaving is taken.
                  for (int i = WLEN - 1; i >= 0; i--) begin
                     if (!found && n_q[l*DEPTH+LO+i] && !cons_q[(p*LANES+l)*WLEN+i]) begin
                        found = 1'b1;
                        cons_d[(p*LANES+l)*WLEN+i] = 1'b1;
                     end
                  end
                  if (found) begin
                     hit_d[p*LANES+l] = 1'b1;
                     hits = hits + 1;
                  end else begin
                     bad = 1'b1;
                  end
               end
               // Uses cons_d so a note hit in its exit cycle is not also a miss.
               if (frame_tick && n_q[l*DEPTH+HI] && !cons_d[(p*LANES+l)*WLEN+WLEN-1])
                  bad = 1'b1;
            end
            miss_d[p] = bad;
            score_d[p*SCORE_W +: SCORE_W] = sat_score(score_q[p*SCORE_W +: SCORE_W], hits * mult);
            combo_d[p*COMBO_W +: COMBO_W] = bad ? '0 : sat_combo(combo_q[p*COMBO_W +: COMBO_W], hits);
         end
         if (frame_tick) begin
            for (int l = 0; l < LANES; l++) begin
               for (int r = DEPTH - 1; r >= 1; r--)
                  n_d[l*DEPTH+r] = n_q[l*DEPTH+r-1];
               n_d[l*DEPTH] = notes_in[l];
            end
            for (int k = 0; k < PLAYERS*LANES; k++) begin
               for (int i = WLEN - 1; i >= 1; i--)
                  cons_d[k*WLEN+i] = cons_d[k*WLEN+i-1];
               cons_d[k*WLEN] = 1'b0;
            end
         end
      end
      if (score_clr) begin
         score_d = '0;
         combo_d = '0;
      end
   end

   // State registers; keys_prev resets high so a key held through reset is not a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q         <= '0;
         cons_q      <= '0;
         score_q     <= '0;
         combo_q     <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
         keys_prev_q <= '1;
      end else begin
         n_q         <= n_d;
         cons_q      <= cons_d;
         score_q     <= score_d;
         combo_q     <= combo_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         keys_prev_q <= keys;
      end
   end

   assign n_reg      = n_q;
   assign score      = score_q;
   assign combo      = combo_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;

endmodule

// File: doc/note_judge.md
# note_judge

Parametrised multi-lane, multi-player note highway and hit judge for the rhythm game. Shifts incoming chart notes down a per-lane highway on each frame tick, detects key-press edges per player, and classifies each as hit, wrong press or miss against a timing window around a target row. Keeps saturating per-player score and combo with a combo-driven multiplier. It generalises the fixed 4-lane note register and scorer pair to arbitrary lanes, players, depth and window, and exports the highway for the framebuffer mapper.

## Interface
- LANES, 4, note lanes per highway
- PLAYERS, 2, independent players sharing one highway
- DEPTH, 360, highway rows (row 0 = entry)
- HIT_ROW, 340, target row; requires WINDOW ≤ HIT_ROW and HIT_ROW+WINDOW ≤ DEPTH-1
- WINDOW, 8, half-width of judge window in rows
- SCORE_W, 10, score width per player
- COMBO_W, 8, combo width per player
- COMBO_STEP, 10, combo hits per multiplier step
- MULT_MAX, 4, multiplier ceiling
- Clk  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  synchronous, active-high
- run  in  1  1 = play; 0 = ignore ticks and key edges
- frame_tick  in  1  one-cycle pulse per video frame, Clk-synchronous
- clear  in  1  flush highway and consumed state; scores and combos untouched
- score_clr  in  1  zero all scores and combos
- notes_in  in  LANES  note bits sampled into row 0 on tick
- keys  in  PLAYERS*LANES  held-key levels, player p lane l at bit p*LANES+l, already synchronised
- n_reg  out  LANES*DEPTH  highway, lane l row r at bit l*DEPTH+r
- score  out  PLAYERS*SCORE_W  per-player score
- combo  out  PLAYERS*COMBO_W  per-player combo
- hit_pulse  out  PLAYERS*LANES  one-cycle hit strobe per player/lane
- miss_pulse  out  PLAYERS  one-cycle strobe: miss or wrong press

## Operation
- Highway: on frame_tick && run, every lane shifts row r→r+1; row 0 ← notes_in[l]; row DEPTH-1 discarded.
- Window rows: HIT_ROW-WINDOW .. HIT_ROW+WINDOW (2*WINDOW+1 rows). Per player, per lane, a window-length consumed vector shifts with the highway; bit entering at HIT_ROW-WINDOW is 0.
- Press edge: keys & ~keys_prev, per bit; keys_prev registered every cycle regardless of run.
- Per edge (player p, lane l), judged against pre-shift state: if any window row holds a note not consumed by p → hit; mark the highest-row such note consumed for p only; else → wrong press.
- Miss: on tick, a note at row HIT_ROW+WINDOW unconsumed by p (including same-cycle hit) → miss for p.
- Multiplier per player = min(1 + combo/COMBO_STEP, MULT_MAX), from start-of-cycle combo.
- Per player per cycle: score += hits × multiplier, saturating at 2^SCORE_W-1. If any wrong press or miss that cycle, combo ← 0; else combo += hits, saturating at 2^COMBO_W-1.
- clear: highway and consumed vectors ← 0 next cycle; no judging that cycle. score_clr: scores, combos ← 0; same-cycle hits dropped. Both may assert together.
- run=0: highway frozen, edges ignored, no pulses; keys_prev still tracks.

## Timing
- Reset: n_reg, consumed, score, combo, hit_pulse, miss_pulse ← 0; keys_prev ← all ones (key held through reset is not a press).
- Edge seen in cycle t (keys high at t, low at t-1) → score, combo, hit_pulse/miss_pulse valid after edge ending cycle t (1-cycle latency).
- Tick in cycle t → n_reg shifted after that edge; miss_pulse in same cycle as shift visible.
- Simultaneous tick and press: judge on pre-shift rows, then consume, then shift; note judged hit at HIT_ROW+WINDOW in the exit cycle is not a miss.
- Pulses are exactly one cycle; no state spans multiple cycles beyond registers (no FSM stalls; accepts an event every cycle).
- Reset has priority over clear/score_clr; score_clr over accumulation.

## Test plan
- Params DEPTH=16, HIT_ROW=12, WINDOW=2, COMBO_STEP=2, MULT_MAX=3, SCORE_W=6. Note on lane 0 at tick 0; 12 more ticks; player 0 lane 0 press → hit_pulse[0]=1, score0=1, combo0=1, player 1 unaffected.
- Same note, no press for 15 ticks → miss_pulse[0] and miss_pulse[1] on tick moving it past row 14; combo cleared; note still visible in n_reg until row 15 drops.
- Press with empty window on lane 2 while combo0=5 → miss_pulse[0], combo0=0, score unchanged.
- Six consecutive hits player 0 → score 1,2,4,6,9,12 (multiplier 1,1,2,2,3,3 capped), combo0=6.
- Score at 62 with multiplier 3 hit → score0=63 saturated; Reset mid-game with key held → all outputs 0, no hit on release of Reset.
- Press and tick same cycle with note at row 14 → hit, no miss; run=0 with tick and press → n_reg, score unchanged.
